cmp_sort_ctrl: RTL and testbench
================================

// Module: cmp_sort_ctrl
// PURPOSE
//  Sequencer that owns one shared combinational magnitude comparator (WIDTH-bit,
//  eq/gt/lt outputs) and uses it to sort a burst of DEPTH unsigned words in ascending order.
//  Words are loaded over a valid/ready input stream. A bubble-sort FSM performs one
//  compare per cycle and returns the sorted words over a valid/ready output stream.
//  Sits between the operand source and the comparator; the comparator stays external.
// PARAMETERS
//  WIDTH  4  data width of every word and of the comparator operands
//  DEPTH  4  words per burst, legal range 2..16
// PORTS
//  clk         in   1      single clock; all state changes on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      source presents in_data
//  in_ready    out  1      block accepts a word (high only in LOAD)
//  in_data     in   WIDTH  word to load
//  out_valid   out  1      out_data holds a sorted word (high only in DRAIN)
//  out_ready   in   1      sink accepts out_data
//  out_data    out  WIDTH  sorted word, smallest first
//  cmp_a       out  WIDTH  comparator operand A
//  cmp_b       out  WIDTH  comparator operand B
//  cmp_a_eq_b  in   1      comparator result A==B (same cycle as operands)
//  cmp_a_gt_b  in   1      comparator result A>B
//  cmp_a_lt_b  in   1      comparator result A<B
//  busy        out  1      high while in SORT
//  cmp_err     out  1      sticky: comparator result was not exactly one-hot
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, buffer and pointers=0, in_ready=1, out_valid=0,
//   out_data=0, cmp_a=cmp_b=0, busy=0, cmp_err=0. Reset mid-burst discards the burst.
//  Transfers occur only on rising edges where valid&&ready are both high.
//  LOAD: in_ready=1. Each accepted word goes to buf[wr_ptr] and wr_ptr++.
//   The DEPTH-th accept moves to SORT on the same edge; wr_ptr returns to 0.
//  SORT: in_ready=0 and busy=1. in_valid is ignored and no word is lost or stored.
//   Each cycle: cmp_a=buf[j], cmp_b=buf[j+1], with j=0..DEPTH-2 within a pass.
//   On the edge, if cmp_a_gt_b, swap buf[j] and buf[j+1] and set the pass_swapped flag.
//   If cmp_a_eq_b or cmp_a_lt_b, there is no swap; equal words never swap.
//   If {eq,gt,lt} is not one-hot, set cmp_err; cmp_err stays set until reset, and there is no swap.
//   At j==DEPTH-2 the pass ends. The block moves to DRAIN if no swap happened in this pass
//   (including the current cycle) or DEPTH-1 passes are done. Otherwise j=0, pass++,
//   and pass_swapped is cleared.
//   SORT takes at least DEPTH-1 cycles (input already sorted) and at most (DEPTH-1)^2 cycles.
//  DRAIN: out_valid=1 and out_data=buf[rd_ptr], combinational from the registered buffer.
//   While out_ready=0, out_data and out_valid hold stable.
//   Each accepted word increments rd_ptr. On the DEPTH-th accept, the block returns to LOAD
//   (in_ready=1 next cycle) and rd_ptr becomes 0.
//  Outside SORT, cmp_a=cmp_b=0 and comparator results are ignored (cmp_err does not update).
//  Back-to-back bursts: the first word of the next burst can be accepted one cycle after
//   the last output accept; there is no overlap of LOAD with DRAIN.
//  Latency: DEPTH load cycles + SORT cycles + DEPTH drain cycles, assuming no stalls.
//  Pointers j, wr_ptr and rd_ptr are clog2(DEPTH) wide. pass is clog2(DEPTH) wide and must
//   never wrap.
// TESTING  (WIDTH=4, DEPTH=4, bench instantiates the team 4-bit comparator)
//  1 Load 13,8,6,7 with out_ready=1 -> out 6,7,8,13; busy high 9 cycles; cmp_err=0.
//  2 Load 3,5,10,15 -> SORT lasts exactly 3 cycles (one pass, no swap); out 3,5,10,15.
//  3 Load 15,12,7,4 -> SORT lasts 9 cycles; out 4,7,12,15.
//   Check that in_valid=1 with data 9 during SORT is never accepted.
//  4 Load 10,10,3,3 -> out 3,3,10,10; each eq compare causes no swap.
//  5 In DRAIN, hold out_ready=0 for 3 cycles after the 2nd word -> out_data stays 7 (vector 3);
//   the sequence completes with no duplicates.
//   Then run a 2nd burst back-to-back and check it is correct.
//  6 Force gt=lt=1 on one SORT compare -> cmp_err=1, no swap at that slot, cmp_err stays set.
//   Assert rst_n=0 mid-SORT -> all outputs return to reset values immediately, state=LOAD.

Source files
------------

// File: rtl/cmp_sort_ctrl.sv
// Burst sorter: loads DEPTH words, bubble-sorts them with one external comparator
// compare per cycle, then streams them out smallest first.
module cmp_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_a_eq_b,
  input  logic             cmp_a_gt_b,
  input  logic             cmp_a_lt_b,
  output logic             busy,
  output logic             cmp_err
);

  // state | meaning
  // LOAD  | accepting DEPTH input words into the buffer
  // SORT  | one compare per cycle, swap buffer pair on gt
  // DRAIN | presenting sorted words, smallest first
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, j, pass;
  logic [PW-1:0]    j_nxt;
  logic             pass_swapped;
  logic             cmp_err_q;

  logic in_accept, out_accept;
  logic res_one_hot, swap_now;
  logic last_cmp, last_pass;
  logic last_wr, last_rd;

  assign j_nxt       = j + PW'(1);
  assign in_accept   = (state == ST_LOAD) && in_valid;
  assign out_accept  = (state == ST_DRAIN) && out_ready;
  assign res_one_hot = ({cmp_a_eq_b, cmp_a_gt_b, cmp_a_lt_b} == 3'b100) ||
                       ({cmp_a_eq_b, cmp_a_gt_b, cmp_a_lt_b} == 3'b010) ||
                       ({cmp_a_eq_b, cmp_a_gt_b, cmp_a_lt_b} == 3'b001);
  assign swap_now    = (state == ST_SORT) && res_one_hot && cmp_a_gt_b;
  assign last_cmp    = (j == PW'(DEPTH - 2));
  assign last_pass   = (pass == PW'(DEPTH - 2));
  assign last_wr     = (wr_ptr == PW'(DEPTH - 1));
  assign last_rd     = (rd_ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (in_accept && last_wr) state_nxt = ST_SORT;
      ST_SORT:  if (last_cmp && (!(pass_swapped || swap_now) || last_pass))
                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_accept && last_rd) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      j            <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      cmp_err_q    <= 1'b0;
    end else begin
      if (in_accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= last_wr ? '0 : wr_ptr + PW'(1);
      end
      if (state == ST_SORT) begin
        if (!res_one_hot) cmp_err_q <= 1'b1;
        if (swap_now) begin
          mem[j]     <= mem[j_nxt];
          mem[j_nxt] <= mem[j];
        end
        // Pass bookkeeping resets at every pass end; leaving SORT also leaves it clean.
        if (last_cmp) begin
          j            <= '0;
          pass_swapped <= 1'b0;
          pass         <= (state_nxt == ST_SORT) ? pass + PW'(1) : '0;
        end else begin
          j            <= j_nxt;
          pass_swapped <= pass_swapped || swap_now;
        end
      end
      if (out_accept) rd_ptr <= last_rd ? '0 : rd_ptr + PW'(1);
    end
  end

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state == ST_SORT);
  assign out_data  = (state == ST_DRAIN) ? mem[rd_ptr] : '0;
  assign cmp_a     = (state == ST_SORT) ? mem[j] : '0;
  assign cmp_b     = (state == ST_SORT) ? mem[j_nxt] : '0;
  assign cmp_err   = cmp_err_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: directed bursts plus random bursts
// compared with a sort/pass-count reference model.
module tb_cmp_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic [3:0] cmp_a, cmp_b;
  logic       eq, gt, lt;
  logic       busy, cmp_err;
  logic       inj = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Comparator model; inj forces a non-one-hot result.
  assign eq = inj ? 1'b0 : (cmp_a == cmp_b);
  assign gt = inj ? 1'b1 : (cmp_a >  cmp_b);
  assign lt = inj ? 1'b1 : (cmp_a <  cmp_b);

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_a_eq_b(eq), .cmp_a_gt_b(gt), .cmp_a_lt_b(lt),
    .busy(busy), .cmp_err(cmp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  task automatic load_words(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[4*i +: 4];
      check("load_ready", in_ready, 1);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Sort cycles = (DEPTH-1) * passes, where passes = largest count of strictly
  // greater words ahead of any word, plus the final clean pass, capped at DEPTH-1.
  task automatic sort_and_drain(input logic [15:0] w, input bit spoof,
                                input int stall_at, input int stall_len);
    int q[$];
    int max_inv, inv, passes, exp_cyc, cyc;
    q = {};
    max_inv = 0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(int'(w[4*i +: 4]));
      inv = 0;
      for (int p = 0; p < i; p++) if (w[4*p +: 4] > w[4*i +: 4]) inv++;
      if (inv > max_inv) max_inv = inv;
    end
    q.sort();
    passes  = (max_inv + 1 > 3) ? 3 : max_inv + 1;
    exp_cyc = 3 * passes;

    if (spoof) begin
      in_valid = 1'b1;
      in_data  = 4'd9;
    end
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      check("sort_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sort_cycles", cyc, exp_cyc);
    check("drain_cmp_a", cmp_a, 0);

    for (int k = 0; k < 4; k++) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, q[k]);
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk);
          @(negedge clk);
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, q[k]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      if (k < 3) @(negedge clk);
    end
    #1;
    check("drain_done_valid", out_valid, 0);
    check("err_clear", cmp_err, 0);
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_err", cmp_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cmp_a", cmp_a, 0);
    rst_n = 1'b1;

    w = pack(13, 8, 6, 7);   load_words(w); sort_and_drain(w, 1'b0, -1, 0);
    w = pack(3, 5, 10, 15);  load_words(w); sort_and_drain(w, 1'b0, -1, 0);
    w = pack(15, 12, 7, 4);  load_words(w); sort_and_drain(w, 1'b1, 1, 3);
    w = pack(10, 10, 3, 3);  load_words(w); sort_and_drain(w, 1'b0, -1, 0);
    w = pack(15, 12, 7, 4);  load_words(w); sort_and_drain(w, 1'b1, 1, 3);
    w = pack(2, 9, 1, 14);   load_words(w); sort_and_drain(w, 1'b0, -1, 0);

    for (int r = 0; r < 8; r++) begin
      w = pack($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      load_words(w);
      sort_and_drain(w, r[0], $urandom_range(0, 4), $urandom_range(1, 3));
    end

    // Non-one-hot comparator result on the first compare.
    w = pack(13, 8, 6, 7);
    load_words(w);
    @(negedge clk);
    check("inj_cmp_a", cmp_a, 13);
    check("inj_cmp_b", cmp_b, 8);
    inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk);
    check("inj_err_set", cmp_err, 1);
    check("inj_no_swap_a", cmp_a, 8);
    check("inj_no_swap_b", cmp_b, 6);
    @(negedge clk);
    check("inj_err_sticky", cmp_err, 1);
    check("inj_busy", busy, 1);

    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", cmp_err, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_cmp_a", cmp_a, 0);
    check("mid_rst_cmp_b", cmp_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    w = pack(11, 0, 5, 5);   load_words(w); sort_and_drain(w, 1'b0, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
